// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage RV32I core.
// Issues load/store requests through an IDLE/REQ/DONE handshake FSM, aligns
// store data and strobes, extends load data, stalls upstream stages until the
// access completes, drives MEM-stage forwarding and holds the MEM/WB register.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        reg_w_in,
    input  logic        wb_sel_in,
    input  logic        rd_src_in,
    input  logic        mem_r_in,
    input  logic        mem_w_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] alu_out_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  rd_addr_in,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic        fwd_we,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic        wb_reg_w,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [3:0]  dm_wstrb_q, dm_wstrb_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [31:0] ld_q, ld_d;
    logic        wb_reg_w_q, wb_reg_w_d;
    logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic        acc;
    logic [1:0]  off;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // A set mem_w_in makes the access a store even if mem_r_in is also set.
    assign acc = mem_r_in | mem_w_in;
    assign off = alu_out_in[1:0];

    // Forwarding is purely a function of the instruction currently in MEM.
    assign fwd_we   = reg_w_in & ~wb_sel_in;
    assign fwd_rd   = rd_addr_in;
    assign fwd_data = rd_src_in ? (pc_in + 32'd4) : alu_out_in;

    // Stall while the access is being launched or is outstanding; DONE never stalls.
    assign mem_stall = ((state_q == IDLE) && acc) || (state_q == REQ);

    // Store lane alignment: replicate the datum and select lanes with strobes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        st_strb  = 4'b1111;
        st_wdata = rs2_data_in;
        case (funct3_in)
            3'b000: begin
                st_strb  = 4'b0001 << off;
                st_wdata = {4{rs2_data_in[7:0]}};
            end
            3'b001: begin
                st_strb  = off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{rs2_data_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane selection and sign/zero extension of the returned word.
    always_comb begin
        ld_byte = dm_rdata[{off, 3'b000} +: 8];
        ld_half = off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        ld_ext  = dm_rdata;
        case (funct3_in)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = dm_rdata;
        endcase
    end

    // Request/acknowledge FSM: launch the access, hold it until ack, capture load data.
    always_comb begin
        state_d    = state_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_wstrb_d = dm_wstrb_q;
        dm_wdata_d = dm_wdata_q;
        ld_d       = ld_q;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    dm_req_d   = 1'b1;
                    dm_we_d    = mem_w_in;
                    dm_addr_d  = {alu_out_in[31:2], 2'b00};
                    dm_wstrb_d = mem_w_in ? st_strb : 4'b0000;
                    dm_wdata_d = mem_w_in ? st_wdata : 32'd0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (dm_ack) begin
                    dm_req_d = 1'b0;
                    ld_d     = ld_ext;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // MEM/WB next value: bubble while stalled, otherwise load data or ALU/link value.
    always_comb begin
        wb_reg_w_d   = 1'b0;
        wb_rd_addr_d = 5'd0;
        wb_data_d    = 32'd0;
        if (!mem_stall) begin
            wb_reg_w_d   = reg_w_in;
            wb_rd_addr_d = rd_addr_in;
            wb_data_d    = wb_sel_in ? ld_q : fwd_data;
        end
    end

    // State, data-memory port and MEM/WB registers; asynchronous reset clears all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dm_req_q     <= 1'b0;
            dm_we_q      <= 1'b0;
            dm_addr_q    <= 32'd0;
            dm_wstrb_q   <= 4'b0000;
            dm_wdata_q   <= 32'd0;
            ld_q         <= 32'd0;
            wb_reg_w_q   <= 1'b0;
            wb_rd_addr_q <= 5'd0;
            wb_data_q    <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            dm_req_q     <= dm_req_d;
            dm_we_q      <= dm_we_d;
            dm_addr_q    <= dm_addr_d;
            dm_wstrb_q   <= dm_wstrb_d;
            dm_wdata_q   <= dm_wdata_d;
            ld_q         <= ld_d;
            wb_reg_w_q   <= wb_reg_w_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign dm_req     = dm_req_q;
    assign dm_we      = dm_we_q;
    assign dm_addr    = dm_addr_q;
    assign dm_wstrb   = dm_wstrb_q;
    assign dm_wdata   = dm_wdata_q;
    assign wb_reg_w   = wb_reg_w_q;
    assign wb_rd_addr = wb_rd_addr_q;
    assign wb_data    = wb_data_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RV32I core. It sits directly downstream of the EX/MEM pipeline register and issues load/store transactions to the data-memory port through a request/acknowledge FSM. It aligns store data and byte strobes, and sign- or zero-extends load data. It stalls the pipeline until the access completes, drives MEM-stage forwarding, and contains the MEM/WB register feeding write-back.

## Interface
- Parameters: none; datapath fixed at 32 bits.
- clk  in  1  clock; all state updates on posedge clk.
- rst  in  1  reset, asynchronous, active-high.
- pc_in  in  32  PC of instruction in MEM.
- reg_w_in  in  1  instruction writes rd.
- wb_sel_in  in  1  1 = write-back value is load data.
- rd_src_in  in  1  1 = write-back value is pc_in+4 (JAL/JALR); 0 = alu_out_in.
- mem_r_in  in  1  load.
- mem_w_in  in  1  store.
- funct3_in  in  3  access size/sign.
- alu_out_in  in  32  effective address or ALU result.
- rs2_data_in  in  32  store data.
- rd_addr_in  in  5  destination register.
- dm_req  out  1  data-memory request, registered.
- dm_we  out  1  1 = write, registered.
- dm_addr  out  32  word address {alu_out_in[31:2],2'b00}, registered.
- dm_wstrb  out  4  byte strobes, registered.
- dm_wdata  out  32  lane-aligned store data, registered.
- dm_ack  in  1  single-cycle completion pulse from memory.
- dm_rdata  in  32  read word, valid when dm_ack=1.
- mem_stall  out  1  freeze EX/MEM and all earlier stages.
- fwd_we  out  1  reg_w_in & ~wb_sel_in.
- fwd_rd  out  5  rd_addr_in.
- fwd_data  out  32  rd_src_in ? pc_in+4 : alu_out_in.
- wb_reg_w  out  1  MEM/WB: write enable.
- wb_rd_addr  out  5  MEM/WB: destination.
- wb_data  out  32  MEM/WB: write-back value.

## Operation
- Access present: acc = mem_r_in | mem_w_in. If both are set, the access is a store.
- FSM states: IDLE, REQ, DONE.
  - IDLE & acc: load dm_* registers, dm_req<=1, go to REQ.
  - REQ & dm_ack: dm_req<=0; latch the extended load value into ld_q; go to DONE.
  - REQ & ~dm_ack: hold all dm_* outputs stable.
  - DONE: go to IDLE unconditionally.
- mem_stall = (IDLE & acc) | REQ, combinational from state and inputs.
- The hazard unit must not flush EX/MEM while mem_stall=1.
- Byte offset off = alu_out_in[1:0].
- Store strobes and data:
  - SB (000): strb = 0001<<off; wdata = {4{rs2[7:0]}}.
  - SH (001): strb = off[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}. off[0] is ignored.
  - SW and all other funct3: strb = 1111; wdata = rs2.
- Loads select a lane by off:
  - LB/LBU (000/100): byte, sign-/zero-extended.
  - LH/LHU (001/101): halfword at off[1], sign-/zero-extended.
  - LW and all other funct3: full word.
- For reads, dm_wstrb = 0000 and dm_we = 0.
- MEM/WB update at every posedge:
  - mem_stall=1: insert a bubble (wb_reg_w<=0, wb_rd_addr<=0, wb_data<=0).
  - Otherwise: wb_reg_w<=reg_w_in, wb_rd_addr<=rd_addr_in.
  - wb_data<= ld_q when wb_sel_in=1; otherwise fwd_data.
- A load in DONE writes back ld_q. A non-memory instruction passes through with no stall.
- dm_ack in IDLE or DONE is ignored.

## Timing
- Non-memory instruction: 1 cycle in MEM, mem_stall=0.
- Memory instruction with ack k cycles after dm_req rises (k≥0 cycles in REQ before ack):
  - cycle 0: IDLE, stall.
  - cycles 1..1+k: REQ, stall.
  - next cycle: DONE, no stall.
  - Total 3+k cycles in MEM. Write-back values appear on the wb_* outputs the cycle after DONE.
- The DONE cycle never stalls, so EX/MEM advances exactly once per access.
- Reset (asynchronous, any state, including mid-REQ): state=IDLE; dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata, ld_q, wb_reg_w, wb_rd_addr, wb_data all 0.
- After reset release, a pending acc restarts from IDLE. A late dm_ack for the aborted request arrives in IDLE and is ignored.
- fwd_* outputs are purely combinational from the inputs and unaffected by state.

## Test plan
- ADD result 0x00000005, rd=3, no access -> mem_stall=0; next cycle wb_reg_w=1, wb_rd_addr=3, wb_data=0x5; fwd_we=1, fwd_data=0x5.
- LB at address 0x1003, memory word 0x80FF_1234, ack 2 cycles after dm_req -> dm_addr=0x1000; mem_stall high for 4 cycles; wb_data=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- SH at address 0x2002, rs2=0xABCD1234 -> dm_we=1, dm_wstrb=1100, dm_wdata=0x12341234; held stable until dm_ack; wb_reg_w=0.
- SB at each offset 0..3 with rs2=0x5A -> strobes 0001/0010/0100/1000; dm_wdata=0x5A5A5A5A.
- rst pulsed mid-REQ of LW, then dm_ack asserted after release -> all outputs 0 during reset; state IDLE; the LW is reissued and the stray ack causes no write-back.
- JAL at pc=0x100, rd=1 -> fwd_data=0x104; wb_data=0x104; no stall.
